// File: rtl/led_pkg.sv
// led_pkg: shared constants and state encoding for the LED panel scan path
// Ports: none (package). DEF_PWM_BITS is also used by the receive stage and colour comparator.
package led_pkg;
    localparam int DEF_COLS     = 64;
    localparam int DEF_ROW_BITS = 4;
    localparam int DEF_PWM_BITS = 6;
    localparam int DEF_PWM_MAX  = 62;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        BLANK = 2'd2,
        LATCH = 2'd3
    } scan_state_t;
endpackage

// File: rtl/led_scan_counters.sv
// led_scan_counters: column, row and PWM counters with wrap flags for the panel scan
// Ports: in_clk/in_rst clock and async reset; col_clr/col_inc column control;
//        row_inc advances row (and PWM on row wrap); col_last/row_last/pwm_last wrap flags;
//        row_addr/pwm_value counter outputs.
module led_scan_counters
    import led_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PWM_MAX  = DEF_PWM_MAX
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                col_clr,
    input  logic                col_inc,
    input  logic                row_inc,
    output logic                col_last,
    output logic                row_last,
    output logic                pwm_last,
    output logic [ROW_BITS-1:0] row_addr,
    output logic [PWM_BITS-1:0] pwm_value
);
    localparam int COL_BITS = $clog2(COLS);
    logic [COL_BITS-1:0] col_cnt;
    assign col_last = col_cnt == COL_BITS'(COLS - 1);
    assign row_last = &row_addr;
    assign pwm_last = pwm_value == PWM_BITS'(PWM_MAX);
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            col_cnt   <= '0;
            row_addr  <= '0;
            pwm_value <= '0;
        end else begin
            if (col_clr)
                col_cnt <= '0;
            else if (col_inc)
                col_cnt <= col_cnt + 1'b1;
            if (row_inc) begin
                row_addr <= row_addr + 1'b1;
                if (row_last)
                    pwm_value <= pwm_last ? '0 : pwm_value + 1'b1;
            end
        end
    end
endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: LED panel scan FSM driving latch, output enable, row address and PWM threshold
// Ports: in_clk/in_rst clock and async active-high reset; enable run/halt; pix_strobe per-pixel shift pulse;
//        pwm_value compare threshold; row_addr panel row; led_lat latch pulse; led_oe_n output enable (low);
//        fifo_rrst frame FIFO read reset pulse; frame_done end-of-last-PWM-pass pulse.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PWM_MAX  = DEF_PWM_MAX
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                enable,
    input  logic                pix_strobe,
    output logic [PWM_BITS-1:0] pwm_value,
    output logic [ROW_BITS-1:0] row_addr,
    output logic                led_lat,
    output logic                led_oe_n,
    output logic                fifo_rrst,
    output logic                frame_done
);
    scan_state_t state, state_nx;
    logic halt, col_clr, col_inc, row_inc, col_last, row_last, pwm_last;
    led_scan_counters #(
        .COLS(COLS), .ROW_BITS(ROW_BITS), .PWM_BITS(PWM_BITS), .PWM_MAX(PWM_MAX)
    ) u_cnt (
        .in_clk(in_clk), .in_rst(in_rst), .col_clr(col_clr), .col_inc(col_inc), .row_inc(row_inc),
        .col_last(col_last), .row_last(row_last), .pwm_last(pwm_last),
        .row_addr(row_addr), .pwm_value(pwm_value)
    );
    // Strobes during BLANK/LATCH belong to the next row, so they are counted rather than dropped.
    always_comb begin
        state_nx = state;
        col_clr  = 1'b0;
        col_inc  = 1'b0;
        row_inc  = 1'b0;
        case (state)
            IDLE: begin
                state_nx = enable ? SHIFT : IDLE;
                col_clr  = enable;
            end
            SHIFT: begin
                state_nx = (pix_strobe && col_last) ? BLANK : SHIFT;
                col_clr  = pix_strobe && col_last;
                col_inc  = pix_strobe && !col_last;
            end
            BLANK: begin
                state_nx = LATCH;
                col_inc  = pix_strobe;
            end
            LATCH: begin
                state_nx = (enable && !halt) ? SHIFT : IDLE;
                col_inc  = pix_strobe;
                row_inc  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    // A halt seen anywhere in a row is remembered so the row still ends in IDLE.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state      <= IDLE;
            halt       <= 1'b0;
            led_lat    <= 1'b0;
            led_oe_n   <= 1'b1;
            fifo_rrst  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            halt       <= (state != IDLE) && (halt || !enable);
            led_lat    <= state_nx == LATCH;
            led_oe_n   <= state_nx != SHIFT;
            fifo_rrst  <= (state_nx == LATCH) && row_last;
            frame_done <= (state_nx == LATCH) && row_last && pwm_last;
        end
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: scoreboard bench for led_scan_ctrl; latch events are checked against queued expectations
module tb_led_scan_ctrl;
    import led_pkg::*;
    typedef struct packed {
        logic [3:0] row;
        logic [5:0] pwm;
        logic       rrst;
        logic       fd;
    } lat_t;
    logic       in_clk = 1'b0, in_rst = 1'b1, enable = 1'b0, pix_strobe = 1'b0;
    logic [5:0] pwm_value;
    logic [3:0] row_addr;
    logic       led_lat, led_oe_n, fifo_rrst, frame_done;
    lat_t       sbq[$];
    int         checks = 0, fails = 0, rrst_cnt = 0, fd_cnt = 0, exp_row = 0, exp_pwm = 0;

    led_scan_ctrl dut (
        .in_clk(in_clk), .in_rst(in_rst), .enable(enable), .pix_strobe(pix_strobe),
        .pwm_value(pwm_value), .row_addr(row_addr), .led_lat(led_lat),
        .led_oe_n(led_oe_n), .fifo_rrst(fifo_rrst), .frame_done(frame_done)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            pix_strobe = 1'b1;
            tick();
            pix_strobe = 1'b0;
            repeat (gap) tick();
        end
    endtask

    // Queue the latch this row will produce, then advance the row/pwm model.
    task automatic push_latch();
        sbq.push_back('{row: 4'(exp_row), pwm: 6'(exp_pwm),
                        rrst: exp_row == 15, fd: exp_row == 15 && exp_pwm == 62});
        if (exp_row == 15) begin
            exp_row = 0;
            exp_pwm = (exp_pwm == 62) ? 0 : exp_pwm + 1;
        end else
            exp_row++;
    endtask

    task automatic slow_row();
        strobes(63, 3);
        push_latch();
        strobes(1, 3);
    endtask

    task automatic fast_row();
        strobes(63, 0);
        push_latch();
        strobes(1, 0);
        repeat (2) tick();
    endtask

    task automatic monitor();
        lat_t e;
        forever begin
            @(negedge in_clk);
            if (!in_rst) begin
                if (fifo_rrst) rrst_cnt++;
                if (frame_done) fd_cnt++;
                if (led_lat) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_latch: latch at row %0d pwm %0d, required none", row_addr, pwm_value);
                    end else begin
                        e = sbq.pop_front();
                        chk("lat_row", row_addr, e.row);
                        chk("lat_pwm", pwm_value, e.pwm);
                        chk("lat_rrst", fifo_rrst, e.rrst);
                        chk("lat_frame_done", frame_done, e.fd);
                        chk("lat_oe_n", led_oe_n, 1);
                    end
                end else if (fifo_rrst || frame_done) begin
                    checks++;
                    fails++;
                    $display("FAIL pulse_outside_latch: rrst %0d frame_done %0d, required 0 0", fifo_rrst, frame_done);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk("rst_lat", led_lat, 0);
        chk("rst_oe_n", led_oe_n, 1);
        chk("rst_rrst", fifo_rrst, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_row", row_addr, 0);
        chk("rst_pwm", pwm_value, 0);
        in_rst = 1'b0;
        repeat (2) tick();
        chk("idle_oe_n", led_oe_n, 1);
        enable = 1'b1;
        tick();
        chk("shift_oe_n", led_oe_n, 0);
        // Row 0 with explicit cycle timing around the 64th strobe.
        strobes(63, 3);
        push_latch();
        pix_strobe = 1'b1;
        tick();
        pix_strobe = 1'b0;
        chk("t1_oe_n", led_oe_n, 1);
        chk("t1_lat", led_lat, 0);
        tick();
        chk("t2_lat", led_lat, 1);
        chk("t2_oe_n", led_oe_n, 1);
        tick();
        chk("t3_row", row_addr, 1);
        chk("t3_oe_n", led_oe_n, 0);
        chk("t3_lat", led_lat, 0);
        tick();
        for (int r = 1; r < 16; r++) slow_row();
        chk("sweep_rrst_cnt", rrst_cnt, 1);
        chk("sweep_row", row_addr, 0);
        chk("sweep_pwm", pwm_value, 1);
        // Extra strobe during BLANK becomes column 0 of the next row.
        strobes(63, 3);
        push_latch();
        strobes(2, 0);
        tick();
        strobes(62, 3);
        push_latch();
        strobes(1, 3);
        chk("inj_row", row_addr, exp_row);
        // Halt mid-row at column 30.
        strobes(30, 3);
        enable = 1'b0;
        strobes(33, 3);
        push_latch();
        strobes(1, 3);
        chk("halt_oe_n", led_oe_n, 1);
        chk("halt_lat", led_lat, 0);
        chk("halt_row", row_addr, exp_row);
        strobes(4, 3);
        chk("halt_hold_oe_n", led_oe_n, 1);
        chk("halt_hold_row", row_addr, exp_row);
        enable = 1'b1;
        tick();
        chk("resume_oe_n", led_oe_n, 0);
        chk("resume_row", row_addr, exp_row);
        chk("resume_pwm", pwm_value, exp_pwm);
        slow_row();
        // Asynchronous reset in the middle of a LATCH cycle.
        strobes(63, 3);
        pix_strobe = 1'b1;
        tick();
        pix_strobe = 1'b0;
        tick();
        chk("pre_rst_lat", led_lat, 1);
        #1;
        in_rst = 1'b1;
        #1;
        chk("arst_lat", led_lat, 0);
        chk("arst_oe_n", led_oe_n, 1);
        chk("arst_row", row_addr, 0);
        chk("arst_pwm", pwm_value, 0);
        chk("arst_rrst", fifo_rrst, 0);
        exp_row = 0;
        exp_pwm = 0;
        tick();
        in_rst = 1'b0;
        chk("post_rst_oe_n", led_oe_n, 1);
        tick();
        chk("post_rst_shift_oe_n", led_oe_n, 0);
        // Full PWM cycle: 63 values x 16 rows until pwm wraps to 0.
        rrst_cnt = 0;
        fd_cnt = 0;
        for (int r = 0; r < 63 * 16; r++) fast_row();
        chk("wrap_pwm", pwm_value, 0);
        chk("wrap_row", row_addr, 0);
        chk("wrap_frame_done_cnt", fd_cnt, 1);
        chk("wrap_rrst_cnt", rrst_cnt, 63);
        for (int i = 0; i < 100 && sbq.size() != 0; i++) tick();
        chk("sb_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
